// File: rtl/dynode_pkg.sv
// Shared record layout, header default and readout state encoding for the
// dynode event FIFO.
package dynode_pkg;

  localparam int ENE_W = 12;
  localparam int TIM_W = 24;
  localparam int PU_W  = 8;
  localparam int SEQ_W = 8;
  localparam int REC_W = SEQ_W + PU_W + ENE_W + TIM_W;

  localparam logic [3:0] HDR_DEFAULT = 4'hD;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_W0   = 2'd1,
    RD_W1   = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [PU_W-1:0]  pu;
    logic [ENE_W-1:0] ene;
    logic [TIM_W-1:0] tim;
  } evrec_t;

  function automatic logic [31:0] mk_word0(input logic [3:0] hdr, input evrec_t r);
    return {hdr, r.pu, 8'h00, r.ene};
  endfunction

  function automatic logic [31:0] mk_word1(input evrec_t r);
    return {r.seq, r.tim};
  endfunction

endpackage

// File: rtl/dynode_evfifo_ram.sv
// Event record storage: synchronous write, asynchronous read, contents never reset.
module dynode_evfifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 52
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dynode_evfifo.sv
// Energy-windowed event FIFO with sequence tagging and a two-word readout
// stream (word0 = header/pulookup/energy, word1 = seq/time).
module dynode_evfifo
  import dynode_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [3:0] HDR   = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enecor_load,
  input  logic [ENE_W-1:0]  dyn_enecor,
  input  logic [TIM_W-1:0]  dyn_evntim,
  input  logic [PU_W-1:0]   pulookup,
  input  logic              win_en,
  input  logic [ENE_W-1:0]  ene_lo,
  input  logic [ENE_W-1:0]  ene_hi,
  input  logic              fifo_clear,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_last,
  output logic [6:0]        fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [15:0]       ovf_count,
  output logic [15:0]       rej_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr, rd_ptr, fill;
  logic [SEQ_W-1:0] seq;
  evrec_t           wr_rec, head_rec;
  logic             in_win, accept, push, pop;

  rd_state_t   state, state_nxt;
  logic [31:0] rd_data_nxt;
  logic        rd_valid_nxt, rd_last_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Extra wrap bit on the pointers: fill == DEPTH sets exactly the top bit.
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_full  = fill[AW];
  assign fifo_empty = (fill == '0);
  assign fifo_count = 7'(fill);

  assign in_win = !win_en || ((dyn_enecor >= ene_lo) && (dyn_enecor <= ene_hi));
  assign accept = enecor_load && !fifo_clear;
  assign push   = accept && in_win && !fifo_full;
  assign pop    = (state == RD_W1) && rd_ready;
  assign wr_rec = {seq, pulookup, dyn_enecor, dyn_evntim};

  dynode_evfifo_ram #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_rec),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head_rec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seq       <= '0;
      ovf_count <= '0;
      rej_count <= '0;
    end else if (fifo_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seq       <= '0;
      ovf_count <= '0;
      rej_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        seq    <= seq + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      // Full is judged on the pre-pop state, so a same-edge pop does not rescue the load.
      if (accept && in_win && fifo_full) ovf_count <= sat_inc(ovf_count);
      if (accept && !in_win)             rej_count <= sat_inc(rej_count);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RD_IDLE;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_data  <= rd_data_nxt;
      rd_valid <= rd_valid_nxt;
      rd_last  <= rd_last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = rd_valid;
    rd_last_nxt  = rd_last;
    if (fifo_clear) begin
      state_nxt    = RD_IDLE;
      rd_valid_nxt = 1'b0;
      rd_last_nxt  = 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          rd_valid_nxt = 1'b0;
          rd_last_nxt  = 1'b0;
          if (!fifo_empty) begin
            rd_data_nxt  = mk_word0(HDR, head_rec);
            rd_valid_nxt = 1'b1;
            state_nxt    = RD_W0;
          end
        end
        RD_W0: begin
          if (rd_ready) begin
            rd_data_nxt = mk_word1(head_rec);
            rd_last_nxt = 1'b1;
            state_nxt   = RD_W1;
          end
        end
        RD_W1: begin
          if (rd_ready) begin
            rd_valid_nxt = 1'b0;
            rd_last_nxt  = 1'b0;
            state_nxt    = RD_IDLE;
          end
        end
        default: begin
          state_nxt    = RD_IDLE;
          rd_valid_nxt = 1'b0;
          rd_last_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dynode_evfifo.md
DYNODE_EVFIFO -- requirements
Module: dynode_evfifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in events; power of two, 4..64.
REQ-002 Parameter HDR, default 4'hD, header nibble in word0[31:28].
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enecor_load  in  1  one-cycle strobe, corrected event present.
REQ-006 dyn_enecor  in  12  corrected energy.
REQ-007 dyn_evntim  in  24  event time; bits [11:8] = phase.
REQ-008 pulookup  in  8  {sample count, phase}.
REQ-009 win_en  in  1  enable energy window filter.
REQ-010 ene_lo  in  12  window lower bound, inclusive.
REQ-011 ene_hi  in  12  window upper bound, inclusive.
REQ-012 fifo_clear  in  1  synchronous flush.
REQ-013 rd_ready  in  1  readout sink ready.
REQ-014 rd_valid  out  1  rd_data valid.
REQ-015 rd_data  out  32  readout word.
REQ-016 rd_last  out  1  marks word1 of a record.
REQ-017 fifo_count  out  7  events stored, 0..DEPTH.
REQ-018 fifo_full  out  1  fifo_count == DEPTH.
REQ-019 fifo_empty  out  1  fifo_count == 0.
REQ-020 ovf_count  out  16  events dropped on full; saturates at 16'hFFFF.
REQ-021 rej_count  out  16  events rejected by window; saturates at 16'hFFFF.

Function
REQ-022 Accept condition: enecor_load=1 and (win_en=0 or ene_lo<=dyn_enecor<=ene_hi), unsigned compare.
REQ-023 Accepted event with fifo_full=0 at the edge is written that edge; seq (8-bit, wraps 255->0) increments.
REQ-024 Accepted event with fifo_full=1 at the edge is dropped; ovf_count +1; seq unchanged; full state uses pre-pop value, even if a pop occurs the same cycle.
REQ-025 Event failing window: dropped, rej_count +1, seq unchanged.
REQ-026 Stored record = {seq, pulookup, dyn_enecor, dyn_evntim} captured at accept edge.
REQ-027 word0 = {HDR, pulookup[7:0], 4'h0, seq[7:4]... } is NOT used; word0 = {HDR, pulookup, 8'h00, enecor}; word1 = {seq, evntim}.
REQ-028 Readout FSM states RD_IDLE, RD_W0, RD_W1; reset state RD_IDLE.
REQ-029 RD_IDLE: fifo_empty=0 -> register word0 of head into rd_data, rd_valid=1, rd_last=0, go RD_W0; else stay, rd_valid=0.
REQ-030 RD_W0: rd_ready=1 -> register word1, rd_last=1, go RD_W1; else hold rd_data/rd_valid stable.
REQ-031 RD_W1: rd_ready=1 -> pop head, rd_valid=0, rd_last=0, go RD_IDLE; else hold.
REQ-032 Latency: event written at edge N is earliest on rd_data with rd_valid after edge N+1; max throughput one event per 3 cycles.
REQ-033 Push and pop same edge with fifo_full=0: both occur, fifo_count unchanged.
REQ-034 Pointers wrap modulo DEPTH; fifo_count derived from pointer difference with extra wrap bit.
REQ-035 fifo_clear=1: next edge pointers, fifo_count, seq, ovf_count, rej_count -> 0, FSM -> RD_IDLE, rd_valid -> 0; same-cycle load discarded, not counted.
REQ-036 rd_data and rd_valid only change on transitions defined above; no combinational path from rd_ready to rd_valid/rd_data.

Reset
REQ-037 reset_n=0 asynchronously forces: rd_valid=0, rd_last=0, rd_data=0, fifo_count=0, fifo_empty=1, fifo_full=0, ovf_count=0, rej_count=0, seq=0, FSM RD_IDLE.
REQ-038 Storage array contents are not reset; unread content is discarded on reset.
REQ-039 Reset deassertion mid-readout resumes from RD_IDLE with empty FIFO.

Structure
REQ-040 Package dynode_pkg holds record widths (12/24/8/8), HDR default, readout state encoding.
REQ-041 One sub-module dynode_evfifo_ram: DEPTH x 52-bit simple dual-port storage, synchronous write, asynchronous read, no reset.

Verification
REQ-042 Single event enecor=12'h3A5, evntim=24'h012345, pulookup=8'h2C, rd_ready=1 -> words 32'hD2C003A5 then 32'h00012345 (rd_last=1), fifo_empty=1 after.
REQ-043 DEPTH+3=19 loads, rd_ready=0 -> fifo_full=1, fifo_count=16, ovf_count=3; drain yields seq 0..15 in order.
REQ-044 win_en=1, lo=100, hi=200; energies 99,100,200,201 -> only 100 and 200 stored, rej_count=2.
REQ-045 rd_ready toggled 1010... during readout -> rd_data/rd_valid stable while rd_ready=0, no word lost or duplicated.
REQ-046 Full FIFO, load coincident with RD_W1 pop -> load dropped, ovf_count +1, fifo_count=15.
REQ-047 fifo_clear and reset_n=0 asserted mid-RD_W0 -> rd_valid=0 next edge / immediately, all counters 0, 257 following events show seq wrap 255->0.
